stopwatch_dp_gen: RTL and testbench

Parametrised stopwatch/timer datapath, the successor to the fixed 100 Hz up-counting stopwatch datapath.
- Adds up/down (timer) mode, preset load, lap capture, a run-state machine and a done pulse.
- Replaces clock gating with a prescaler clock-enable.
- Sits between the button/UART control FSM and the FND/display mux. It feeds live time and frozen lap time.

---
 rtl/stopwatch_dp_gen_pkg.sv | 22 ++
 rtl/stopwatch_dp_gen_digit_counter.sv | 46 ++++
 rtl/stopwatch_dp_gen.sv | 173 +++++++++++++++++
 tb/tb_stopwatch_dp_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_dp_gen_pkg.sv
// Shared types and constants for the stopwatch/timer datapath.
// The load clamp lives here so every field saturates the same way.
package sw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    DONE = 2'd3
  } sw_state_e;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;

  function automatic int unsigned sw_clamp(input int unsigned v, input int unsigned max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/stopwatch_dp_gen_digit_counter.sv
// One modulo-MOD field of the time chain; carry/borrow are combinational so the
// next field advances on the same edge.
module sw_digit_counter
  import sw_pkg::*;
#(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dir,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         carry_out,
  output logic         borrow_out
);

  localparam logic [W-1:0] MAXV = W'(MOD - 1);

  logic [W-1:0] count_q, count_d;

  assign count      = count_q;
  assign carry_out  = en && (dir == MODE_UP)   && (count_q == MAXV);
  assign borrow_out = en && (dir == MODE_DOWN) && (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (dir == MODE_DOWN) count_d = (count_q == '0)   ? MAXV : count_q - 1'b1;
      else                  count_d = (count_q == MAXV) ? '0   : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/stopwatch_dp_gen.sv
// Stopwatch/timer datapath: prescaler clock-enable, up/down field chain,
// run-state machine, lap capture and down-count expiry pulse.
module stopwatch_dp_gen
  import sw_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100,
  parameter int HOUR_MOD = 24,
  parameter int HOUR_W   = 6,
  localparam int DIV     = CLK_FREQ / TICK_HZ,
  localparam int MSEC_W  = $clog2(TICK_HZ),
  localparam int PRE_W   = $clog2(DIV)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_run_stop,
  input  logic              i_clear,
  input  logic              i_mode,
  input  logic              i_load,
  input  logic [5:0]        i_load_sec,
  input  logic [5:0]        i_load_min,
  input  logic [HOUR_W-1:0] i_load_hour,
  input  logic              i_lap,
  output logic [MSEC_W-1:0] o_msec,
  output logic [5:0]        o_sec,
  output logic [5:0]        o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic [MSEC_W-1:0] o_lap_msec,
  output logic [5:0]        o_lap_sec,
  output logic [5:0]        o_lap_min,
  output logic [HOUR_W-1:0] o_lap_hour,
  output logic              o_lap_valid,
  output logic              o_running,
  output logic              o_done
);

  sw_state_e         state_q, state_d;
  logic              mode_q, mode_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic              done_q, done_d;
  logic              running_q;

  logic [MSEC_W-1:0] lap_msec_q;
  logic [5:0]        lap_sec_q, lap_min_q;
  logic [HOUR_W-1:0] lap_hour_q;
  logic              lap_valid_q;

  logic              load_ok, tick_en, tick_apply, all_zero, start_ok, lap_ok;
  logic              ms_cy, ms_bw, s_cy, s_bw, m_cy, m_bw;
  logic              unused_hr_cy, unused_hr_bw;
  logic [5:0]        sec_ld, min_ld;
  logic [HOUR_W-1:0] hour_ld;

  assign all_zero = (o_msec == '0) && (o_sec == '0) && (o_min == '0) && (o_hour == '0);
  assign load_ok  = i_load && !i_clear && (state_q != RUN);
  assign tick_en  = (state_q == RUN) && (presc_q == PRE_W'(DIV - 1));
  // A down tick at zero is swallowed and turned into expiry instead.
  assign tick_apply = tick_en && !i_clear && !((mode_q == MODE_DOWN) && all_zero);
  assign start_ok   = !((i_mode == MODE_DOWN) && all_zero);
  assign lap_ok     = i_lap && !i_clear && !load_ok && ((state_q == RUN) || (state_q == STOP));

  assign sec_ld  = 6'(sw_clamp(32'(i_load_sec), SEC_MOD - 1));
  assign min_ld  = 6'(sw_clamp(32'(i_load_min), MIN_MOD - 1));
  assign hour_ld = HOUR_W'(sw_clamp(32'(i_load_hour), HOUR_MOD - 1));

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (i_clear) begin
      state_d = IDLE;
    end else if (load_ok) begin
      state_d = STOP;
    end else begin
      case (state_q)
        IDLE, STOP: if (i_run_stop && start_ok) state_d = RUN;
        RUN: begin
          if (i_run_stop) begin
            state_d = STOP;
          end else if (tick_en && (mode_q == MODE_DOWN) && all_zero) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    mode_d = mode_q;
    if ((state_d == RUN) && (state_q != RUN)) mode_d = i_mode;
  end

  always_comb begin
    presc_d = '0;
    if (!i_clear && !load_ok) begin
      case (state_q)
        RUN:     presc_d = tick_en ? '0 : presc_q + 1'b1;
        STOP:    presc_d = presc_q;
        default: presc_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= MODE_UP;
      presc_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      running_q <= (state_d == RUN);
    end
  end

  // Lap samples the pre-tick live values; load leaves an existing capture alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_msec_q  <= '0;
      lap_sec_q   <= '0;
      lap_min_q   <= '0;
      lap_hour_q  <= '0;
      lap_valid_q <= 1'b0;
    end else if (i_clear) begin
      lap_msec_q  <= '0;
      lap_sec_q   <= '0;
      lap_min_q   <= '0;
      lap_hour_q  <= '0;
      lap_valid_q <= 1'b0;
    end else if (lap_ok) begin
      lap_msec_q  <= o_msec;
      lap_sec_q   <= o_sec;
      lap_min_q   <= o_min;
      lap_hour_q  <= o_hour;
      lap_valid_q <= 1'b1;
    end
  end

  sw_digit_counter #(.MOD(TICK_HZ), .W(MSEC_W)) u_msec (
    .clk(clk), .reset(reset), .en(tick_apply), .dir(mode_q), .load(load_ok),
    .load_val('0), .clr(i_clear), .count(o_msec), .carry_out(ms_cy), .borrow_out(ms_bw)
  );

  sw_digit_counter #(.MOD(SEC_MOD), .W(6)) u_sec (
    .clk(clk), .reset(reset), .en(ms_cy | ms_bw), .dir(mode_q), .load(load_ok),
    .load_val(sec_ld), .clr(i_clear), .count(o_sec), .carry_out(s_cy), .borrow_out(s_bw)
  );

  sw_digit_counter #(.MOD(MIN_MOD), .W(6)) u_min (
    .clk(clk), .reset(reset), .en(s_cy | s_bw), .dir(mode_q), .load(load_ok),
    .load_val(min_ld), .clr(i_clear), .count(o_min), .carry_out(m_cy), .borrow_out(m_bw)
  );

  sw_digit_counter #(.MOD(HOUR_MOD), .W(HOUR_W)) u_hour (
    .clk(clk), .reset(reset), .en(m_cy | m_bw), .dir(mode_q), .load(load_ok),
    .load_val(hour_ld), .clr(i_clear), .count(o_hour),
    .carry_out(unused_hr_cy), .borrow_out(unused_hr_bw)
  );

  assign o_lap_msec  = lap_msec_q;
  assign o_lap_sec   = lap_sec_q;
  assign o_lap_min   = lap_min_q;
  assign o_lap_hour  = lap_hour_q;
  assign o_lap_valid = lap_valid_q;
  assign o_running   = running_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_stopwatch_dp_gen.sv
// Bench for stopwatch_dp_gen: directed scenarios plus random pulses, every cycle
// checked against a model that keeps time as a single tick total.
module tb_stopwatch_dp_gen;

  localparam int CLK_FREQ = 1000;
  localparam int TICK_HZ  = 10;
  localparam int HOUR_MOD = 24;
  localparam int HOUR_W   = 6;
  localparam int MSEC_W   = 4;
  localparam int DIV      = CLK_FREQ / TICK_HZ;
  localparam int TOT      = TICK_HZ * 3600 * HOUR_MOD;

  logic clk, reset;
  logic i_run_stop, i_clear, i_mode, i_load, i_lap;
  logic [5:0] i_load_sec, i_load_min;
  logic [HOUR_W-1:0] i_load_hour;
  logic [MSEC_W-1:0] o_msec, o_lap_msec;
  logic [5:0] o_sec, o_min, o_lap_sec, o_lap_min;
  logic [HOUR_W-1:0] o_hour, o_lap_hour;
  logic o_lap_valid, o_running, o_done;

  int tests = 0;
  int fails = 0;

  // Model: 0 idle, 1 run, 2 stop, 3 done; time as total ticks.
  int m_state, m_mode, m_pre, m_t, m_lap, m_lapv, m_done;

  stopwatch_dp_gen #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ), .HOUR_MOD(HOUR_MOD), .HOUR_W(HOUR_W)) dut (
    .clk(clk), .reset(reset), .i_run_stop(i_run_stop), .i_clear(i_clear), .i_mode(i_mode),
    .i_load(i_load), .i_load_sec(i_load_sec), .i_load_min(i_load_min), .i_load_hour(i_load_hour),
    .i_lap(i_lap), .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
    .o_lap_msec(o_lap_msec), .o_lap_sec(o_lap_sec), .o_lap_min(o_lap_min), .o_lap_hour(o_lap_hour),
    .o_lap_valid(o_lap_valid), .o_running(o_running), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [46:0] obs_vec = {o_msec, o_sec, o_min, o_hour, o_lap_msec, o_lap_sec, o_lap_min,
                         o_lap_hour, o_lap_valid, o_running, o_done};

  function automatic logic [46:0] exp_vec();
    return {4'(m_t % 10), 6'((m_t / 10) % 60), 6'((m_t / 600) % 60), 6'(m_t / 36000),
            4'(m_lap % 10), 6'((m_lap / 10) % 60), 6'((m_lap / 600) % 60), 6'(m_lap / 36000),
            1'(m_lapv), 1'(m_state == 1), 1'(m_done)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_mode = 0; m_pre = 0; m_t = 0; m_lap = 0; m_lapv = 0; m_done = 0;
  endtask

  task automatic model_step();
    bit tick, expire;
    int s, mi, h;
    if (reset) begin
      model_reset();
      return;
    end
    tick   = (m_state == 1) && (m_pre == DIV - 1);
    expire = 1'b0;
    m_done = 0;
    if (i_clear) begin
      m_state = 0; m_pre = 0; m_t = 0; m_lap = 0; m_lapv = 0;
    end else if (i_load && m_state != 1) begin
      s  = (i_load_sec > 59) ? 59 : int'(i_load_sec);
      mi = (i_load_min > 59) ? 59 : int'(i_load_min);
      h  = (i_load_hour > HOUR_MOD - 1) ? HOUR_MOD - 1 : int'(i_load_hour);
      m_t = ((h * 60 + mi) * 60 + s) * TICK_HZ;
      m_pre = 0; m_state = 2;
    end else begin
      if (i_lap && (m_state == 1 || m_state == 2)) begin
        m_lap = m_t; m_lapv = 1;
      end
      if (tick) begin
        if (m_mode == 1) begin
          if (m_t == 0) expire = 1'b1;
          else m_t = m_t - 1;
        end else m_t = (m_t + 1) % TOT;
      end
      case (m_state)
        1: m_pre = tick ? 0 : m_pre + 1;
        2: m_pre = m_pre;
        default: m_pre = 0;
      endcase
      case (m_state)
        0, 2: if (i_run_stop && !(i_mode && m_t == 0)) begin m_state = 1; m_mode = int'(i_mode); end
        1: if (i_run_stop) m_state = 2;
           else if (expire) begin m_state = 3; m_done = 1; end
        default: ;
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("cycle", 64'(obs_vec), 64'(exp_vec()));
    i_run_stop = 0; i_clear = 0; i_load = 0; i_lap = 0;
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic do_load(input int s, input int mi, input int h);
    i_load = 1; i_load_sec = 6'(s); i_load_min = 6'(mi); i_load_hour = HOUR_W'(h);
    cyc();
  endtask

  initial begin
    reset = 1; i_run_stop = 0; i_clear = 0; i_mode = 0; i_load = 0; i_lap = 0;
    i_load_sec = 0; i_load_min = 0; i_load_hour = 0;
    model_reset();
    #12;
    chk("reset_vec", 64'(obs_vec), 64'(0));
    @(posedge clk); #1; reset = 0;

    // Up count: 1000 clk = 10 ticks = 1 s, then freeze.
    i_run_stop = 1; cyc();
    run_cycles(1000);
    chk("up_sec", 64'(o_sec), 64'(1));
    chk("up_msec", 64'(o_msec), 64'(0));
    chk("up_running", 64'(o_running), 64'(1));
    i_run_stop = 1; cyc();
    run_cycles(500);
    chk("frozen_sec", 64'(o_sec), 64'(1));
    chk("frozen_msec", 64'(o_msec), 64'(0));
    chk("frozen_running", 64'(o_running), 64'(0));

    // Full rollover in up mode.
    i_clear = 1; cyc();
    do_load(59, 59, 23);
    i_run_stop = 1; cyc();
    run_cycles(1000);
    chk("roll_time", 64'({o_hour, o_min, o_sec, o_msec}), 64'(0));
    chk("roll_done", 64'(o_done), 64'(0));
    chk("roll_running", 64'(o_running), 64'(1));

    // Down expiry; zero-down start is refused.
    i_clear = 1; cyc();
    i_mode = 1; i_run_stop = 1; cyc();
    chk("zero_down_start", 64'(o_running), 64'(0));
    do_load(1, 0, 0);
    i_run_stop = 1; cyc();
    run_cycles(1000);
    chk("down_zero", 64'({o_sec, o_msec}), 64'(0));
    chk("down_not_done", 64'(o_done), 64'(0));
    run_cycles(100);
    chk("down_done", 64'(o_done), 64'(1));
    chk("down_running", 64'(o_running), 64'(0));
    cyc();
    chk("done_one_cycle", 64'(o_done), 64'(0));
    i_mode = 0; i_run_stop = 1; cyc();
    chk("done_ignores_rs", 64'(o_running), 64'(0));

    // Lap on the tick cycle at 0:0:3.4.
    i_clear = 1; cyc();
    i_run_stop = 1; cyc();
    run_cycles(3499);
    i_lap = 1; cyc();
    chk("lap_msec", 64'(o_lap_msec), 64'(4));
    chk("lap_sec", 64'(o_lap_sec), 64'(3));
    chk("lap_valid", 64'(o_lap_valid), 64'(1));
    chk("lap_live_msec", 64'(o_msec), 64'(5));

    // Clear beats load and run_stop.
    i_clear = 1; i_run_stop = 1; i_load = 1; i_load_sec = 7; cyc();
    chk("prio_time", 64'({o_hour, o_min, o_sec, o_msec}), 64'(0));
    chk("prio_lap", 64'(o_lap_valid), 64'(0));
    chk("prio_running", 64'(o_running), 64'(0));

    // Clamp, then load ignored in RUN.
    do_load(63, 10, 30);
    chk("clamp_sec", 64'(o_sec), 64'(59));
    chk("clamp_hour", 64'(o_hour), 64'(23));
    chk("clamp_min", 64'(o_min), 64'(10));
    chk("clamp_stop", 64'(o_running), 64'(0));
    i_run_stop = 1; cyc();
    do_load(5, 5, 5);
    chk("run_load_ignored", 64'(o_sec), 64'(59));

    // Random pulses against the model, with an async reset mid-way.
    for (int k = 0; k < 5000; k++) begin
      i_run_stop = ($urandom_range(0, 99) < 3);
      i_clear    = ($urandom_range(0, 999) < 3);
      i_load     = ($urandom_range(0, 999) < 8);
      i_lap      = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 2) i_mode = ~i_mode;
      i_load_sec  = 6'($urandom_range(0, 3) == 0 ? $urandom_range(0, 63) : $urandom_range(0, 2));
      i_load_min  = 6'($urandom_range(0, 3) == 0 ? $urandom_range(0, 63) : 0);
      i_load_hour = HOUR_W'($urandom_range(0, 7) == 0 ? $urandom_range(0, 63) : 0);
      cyc();
      if (k == 2500) begin
        reset = 1; #2;
        model_reset();
        chk("async_reset", 64'(obs_vec), 64'(exp_vec()));
        cyc();
        reset = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
